// File: rtl/traffic_pkg.sv
// Shared intersection definitions: light-code constants, light bit indices
// and the east-west detector state encoding.
package traffic_pkg;

  // Light vector layout is {gns, yns, rns, gew, yew, rew}
  localparam logic [5:0] GNSL = 6'b100001;
  localparam logic [5:0] YNSL = 6'b010001;
  localparam logic [5:0] GEWL = 6'b001100;
  localparam logic [5:0] YEWL = 6'b001010;

  localparam int GEW_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_REQ   = 3'b010,
    ST_SERVE = 3'b100
  } det_state_t;

  function automatic logic lights_legal(input logic [5:0] code);
    return (code == GNSL) || (code == YNSL) || (code == GEWL) || (code == YEWL);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer on the raw loop sensor followed by a debounce
// counter that only moves the presence output after DB_CYCLES agreeing samples.
module sensor_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic car_present
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_present;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the sync chain two stages deep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_present <= 1'b0;
    end else begin
      r_sync1 <= loop_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_present) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_present <= ~r_present;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign car_present = r_present;

endmodule

// File: rtl/ew_car_detector.sv
// East-west vehicle detector: debounced presence, latching service request
// towards the controller, per-request wait measurement and light-code checker.
module ew_car_detector
  import traffic_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int WAIT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loop_raw,
  input  logic [5:0]        lights,
  output logic              carew,
  output logic              car_present,
  output logic [WAIT_W-1:0] last_wait,
  output logic              lights_err
);

  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  logic              w_car_present;
  logic              w_gew;
  det_state_t        r_state;
  logic              r_carew;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] r_last_wait;
  logic              r_lights_err;

  sensor_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .loop_raw    (loop_raw),
    .car_present (w_car_present)
  );

  assign w_gew = lights[GEW_BIT];

  // The request latches in REQ; presence is only consulted from IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_carew     <= 1'b0;
      r_wait_cnt  <= '0;
      r_last_wait <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_car_present && !w_gew) begin
            r_state    <= ST_REQ;
            r_carew    <= 1'b1;
            r_wait_cnt <= WAIT_ONE;
          end
        end
        ST_REQ: begin
          if (w_gew) begin
            r_state     <= ST_SERVE;
            r_carew     <= 1'b0;
            r_last_wait <= r_wait_cnt;
          end else if (r_wait_cnt != WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
        end
        ST_SERVE: begin
          if (!w_gew) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_carew <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lights_err <= 1'b0;
    end else if (!lights_legal(lights)) begin
      r_lights_err <= 1'b1;
    end
  end

  assign carew       = r_carew;
  assign car_present = w_car_present;
  assign last_wait   = r_last_wait;
  assign lights_err  = r_lights_err;

endmodule
